// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    localparam int PORT_C  = 0;
    localparam int PORT_D  = 1;
    localparam int LAT_MAX = 4;
    localparam int CNT_W   = $clog2(LAT_MAX);

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin pick: one-hot winner from the requests and the last-granted port.
module mem_arb_rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_d,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            // On a tie the port that was not served last goes first.
            2'b11:   win = last_d ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between core (C) and loader (D), round-robin on ties.
// Latency: request seen in IDLE at cycle N -> ready at N+LAT+1; one access per LAT+2 cycles.
// Backpressure: requesters hold req/we/adr/wd until their one-cycle ready pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_adr,
    input  logic [DW-1:0] c_wd,
    output logic [DW-1:0] c_rd,
    output logic          c_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wd,
    output logic [DW-1:0] d_rd,
    output logic          d_ready,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_adr,
    output logic [DW-1:0] m_wd,
    input  logic [DW-1:0] m_rd,
    output logic [1:0]    gnt
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_d;
    logic             lat_we;
    logic [AW-1:0]    lat_adr;
    logic [DW-1:0]    lat_wd;
    logic [1:0]       win;

    mem_arb_rr_pick u_pick (
        .req    ({d_req, c_req}),
        .last_d (last_d),
        .win    (win)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (|win) state_nxt = ST_ACCESS;
            ST_ACCESS: if (cnt == '0) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt     <= 2'b00;
            cnt     <= '0;
            last_d  <= 1'b1;
            lat_we  <= 1'b0;
            lat_adr <= '0;
            lat_wd  <= '0;
            c_rd    <= '0;
            d_rd    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|win) begin
                        gnt     <= win;
                        cnt     <= CNT_LOAD;
                        lat_we  <= win[PORT_D] ? d_we  : c_we;
                        lat_adr <= win[PORT_D] ? d_adr : c_adr;
                        lat_wd  <= win[PORT_D] ? d_wd  : c_wd;
                    end
                end
                ST_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!lat_we) begin
                        if (gnt[PORT_D]) d_rd <= m_rd;
                        else             c_rd <= m_rd;
                    end
                end
                ST_DONE: begin
                    gnt    <= 2'b00;
                    last_d <= gnt[PORT_D];
                end
                default: ;
            endcase
        end
    end

    // Write strobe only on the first access cycle so a multi-cycle memory sees one write.
    assign m_en    = (state == ST_ACCESS);
    assign m_we    = m_en && lat_we && (cnt == CNT_LOAD);
    assign m_adr   = lat_adr;
    assign m_wd    = lat_wd;
    assign c_ready = (state == ST_DONE) && gnt[PORT_C];
    assign d_ready = (state == ST_DONE) && gnt[PORT_D];

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single-port unified instruction/data memory of the multi-cycle ARM core between two requesters: the core's memory interface (port C) and a debug/program-loader master (port D).
Sits between the arm core and the mem block inside top.
- Serialises accesses with a small FSM and a programmable wait-state counter.
- Uses round-robin on contention, so the loader can fill or inspect RAM while the core runs.

Parameters:
AW, 32, address width
DW, 32, data width
LAT, 1, memory access latency in cycles (legal 1..4)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
c_req  input  1  core requests an access; held until c_ready
c_we  input  1  core access is a write
c_adr  input  AW  core byte address
c_wd  input  DW  core write data
c_rd  output  DW  core read data, valid with c_ready
c_ready  output  1  one-cycle pulse: core access complete
d_req  input  1  loader requests an access; held until d_ready
d_we  input  1  loader access is a write
d_adr  input  AW  loader byte address
d_wd  input  DW  loader write data
d_rd  output  DW  loader read data, valid with d_ready
d_ready  output  1  one-cycle pulse: loader access complete
m_en  output  1  memory access active
m_we  output  1  memory write strobe
m_adr  output  AW  memory address
m_wd  output  DW  memory write data
m_rd  input  DW  memory read data
gnt  output  2  one-hot current owner: bit0 = C, bit1 = D; 00 when idle

Behaviour:
- Reset (reset=0, takes effect immediately):
  - All outputs are 0: c_ready, d_ready, m_en, m_we, m_adr, m_wd, c_rd, d_rd, gnt.
  - FSM goes to IDLE.
  - last-granted pointer is set to D, so C wins the first tie.
  - An in-flight access is aborted; no ready pulse is issued for it.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Any req: choose the winner and latch its we/adr/wd into internal registers.
  - Set gnt, load the wait counter with LAT-1, go to ACCESS.
- Winner selection:
  - Exactly one req: that requester wins.
  - Both req: the requester not equal to last-granted wins.
- ACCESS:
  - m_en=1; m_adr and m_wd come from the latched registers.
  - m_we=1 only on the first ACCESS cycle of a write.
  - Counter decrements each cycle; at 0, go to DONE.
  - Reads: m_rd is captured into the winner's rd register at the end of the final ACCESS cycle.
- DONE:
  - Winner's ready=1 for exactly this cycle; m_en=0.
  - last-granted is updated to the winner; go to IDLE; gnt goes to 00 on leaving DONE.
- Timing:
  - A request sampled in IDLE at cycle N gives ready in cycle N+LAT+1.
  - Throughput is one access per LAT+2 cycles.
- Requester protocol:
  - req, we, adr and wd are held until ready.
  - req must be deasserted in the cycle after ready unless a new access is intended.
  - A req still high in the following IDLE is treated as a new access.
- Late changes:
  - req dropped or adr changed after grant: ignored. The latched transaction completes and ready still pulses.
- Read-data hold: c_rd/d_rd keep the last read value until that port's next read completes. Writes leave rd unchanged.
- Loser port: never sees ready and its inputs are not latched; it is re-evaluated in the next IDLE.
- Starvation: with both requesters held continuously, grants alternate C, D, C, D.
- Addressing: no address decoding or alignment checks; m_adr is passed through unmodified.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/ACCESS/DONE).
  - Port index constants PORT_C=0, PORT_D=1.
  - LAT_MAX=4 and the counter width derived from it.
- One natural sub-module: mem_arb_rr_pick.
  - Inputs: two reqs and last-granted.
  - Output: one-hot winner.
  - Purely combinational; reused for future extra masters.

Test Plan:
- Core read, LAT=2: c_req=1, c_we=0, c_adr=0x00000008, m_rd=0xE3A00005.
  - gnt=01; m_en high 2 cycles; c_ready pulses at N+3; c_rd=0xE3A00005; d_ready stays 0.
- Loader write, LAT=2: d_req=1, d_we=1, d_adr=0x00000040, d_wd=0xDEADBEEF.
  - m_we high exactly one cycle with m_adr=0x40, m_wd=0xDEADBEEF; d_ready at N+3; d_rd unchanged (0).
- Contention: both reqs asserted from reset and held.
  - Grant order C, D, C, D.
  - Each ready is a single pulse spaced LAT+2 cycles apart.
  - No cycle ever has c_ready and d_ready both high.
- Reset mid-ACCESS: reset=0 during an active core write.
  - m_en, m_we, gnt and ready drop to 0 without waiting for clk.
  - After release with both requesting, C is granted first.
- Back-to-back core reads, LAT=1: c_req held with addresses 0x0, 0x4, 0x8 and m_rd=0x11/0x22/0x33.
  - c_ready every 3 cycles; c_rd shows 0x11, then 0x22, then 0x33.
- Late req drop: d_req deasserted one cycle after grant, LAT=3.
  - Access still completes; d_ready pulses at N+4; next IDLE with no req stays idle.
